// File: rtl/sign_packer.sv
// sign_packer
//   Snapshots the DIM sign bits from the bipolar vote counters on a capture
//   pulse and streams them out as 32-bit words over a valid/ready master port.
//   Once the signs are captured, the counter array can restart while the
//   words drain at whatever rate the output DMA/FIFO accepts them.
//
// Ports
//   clk, rst   clock; synchronous active-high reset
//   capture    1-cycle pulse: sign_vec is final, take a snapshot
//   sign_vec   DIM sign bits, counter k on bit k
//   m_data     output word i = snapshot[32*i+31 : 32*i]
//   m_valid    m_data valid (high while streaming)
//   m_last     high with the final word
//   m_ready    downstream accepts when m_valid && m_ready
//   busy       a snapshot is held and streaming
//   overrun    sticky: a capture arrived while busy (cleared only by rst)
//   ones_cnt   number of 1 bits in the last completely streamed vector
//   ones_vld   1-cycle pulse when ones_cnt is updated
//
// Configuration macro
//   SIGN_PACK_POPCNT_EN  enables the running popcount behind ones_cnt/ones_vld;
//                        when undefined, both outputs are tied to 0.

module sign_packer #(
  parameter int DIM = 1024,
  localparam int NWORD = DIM / 32,
  localparam int CW = $clog2(NWORD + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic [DIM-1:0]  sign_vec,
  output logic [31:0]     m_data,
  output logic            m_valid,
  output logic            m_last,
  input  logic            m_ready,
  output logic            busy,
  output logic            overrun,
  output logic [CW+4:0]   ones_cnt,
  output logic            ones_vld
);

  // Index width just large enough to select one of NWORD words.
  localparam int IW = (NWORD > 1) ? $clog2(NWORD) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NWORD - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [NWORD-1:0][31:0]  snap_q, snap_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           idx_nxt;
  logic [31:0]             m_data_q, m_data_d;
  logic                    m_last_q, m_last_d;
  logic                    overrun_q, overrun_d;
  logic                    handshake;

`ifdef SIGN_PACK_POPCNT_EN
  localparam int CNTW = CW + 5;
  logic [CNTW-1:0]         acc_q, acc_d;
  logic [CNTW-1:0]         ones_cnt_q, ones_cnt_d;
  logic                    ones_vld_q, ones_vld_d;
  logic [5:0]              word_pop;
`endif

  assign handshake = (state_q == SEND) && m_ready;
  assign idx_nxt   = idx_q + CW'(1);

  // Next-state logic. m_data/m_last are registered and only move on a
  // handshake, so they stay stable under backpressure.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    overrun_d = overrun_q;
`ifdef SIGN_PACK_POPCNT_EN
    acc_d      = acc_q;
    ones_cnt_d = ones_cnt_q;
    ones_vld_d = 1'b0;
    word_pop   = 6'($countones(m_data_q));
`endif

    case (state_q)
      IDLE: begin
        if (capture) begin
          snap_d   = sign_vec;
          idx_d    = '0;
          m_data_d = sign_vec[31:0];
          m_last_d = (NWORD == 1);
          state_d  = SEND;
`ifdef SIGN_PACK_POPCNT_EN
          acc_d    = '0;
`endif
        end
      end
      SEND: begin
        // A capture while streaming is dropped, even on the last handshake.
        if (capture) begin
          overrun_d = 1'b1;
        end
        if (handshake) begin
          if (idx_q == LAST_IDX) begin
            state_d  = IDLE;
            m_last_d = 1'b0;
`ifdef SIGN_PACK_POPCNT_EN
            ones_cnt_d = acc_q + CNTW'(word_pop);
            ones_vld_d = 1'b1;
`endif
          end else begin
            idx_d    = idx_nxt;
            m_data_d = snap_q[idx_nxt[IW-1:0]];
            m_last_d = (idx_nxt == LAST_IDX);
`ifdef SIGN_PACK_POPCNT_EN
            acc_d    = acc_q + CNTW'(word_pop);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset discards the snapshot and aborts any stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SIGN_PACK_POPCNT_EN
      acc_q      <= '0;
      ones_cnt_q <= '0;
      ones_vld_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      overrun_q <= overrun_d;
`ifdef SIGN_PACK_POPCNT_EN
      acc_q      <= acc_d;
      ones_cnt_q <= ones_cnt_d;
      ones_vld_q <= ones_vld_d;
`endif
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = (state_q == SEND);
  assign m_last  = m_last_q;
  assign busy    = (state_q == SEND);
  assign overrun = overrun_q;

`ifdef SIGN_PACK_POPCNT_EN
  assign ones_cnt = ones_cnt_q;
  assign ones_vld = ones_vld_q;
`else
  assign ones_cnt = '0;
  assign ones_vld = 1'b0;
`endif

endmodule

// File: tb/tb_sign_packer.sv
// tb_sign_packer
//   Directed bench for sign_packer: a DIM=64 instance for the reset, basic,
//   backpressure, popcount, overrun and mid-stream reset scenarios, and a
//   DIM=1024 instance fed random vectors with random m_ready.

module tb_sign_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   errors = 0;
  int   checks = 0;

  // DIM=64 instance
  logic        capture_a;
  logic [63:0] vec_a;
  logic [31:0] m_data_a;
  logic        m_valid_a, m_last_a, m_ready_a, busy_a, overrun_a, ones_vld_a;
  logic [6:0]  ones_cnt_a;

  // DIM=1024 instance
  logic          capture_b;
  logic [1023:0] vec_b;
  logic [31:0]   m_data_b;
  logic          m_valid_b, m_last_b, m_ready_b, busy_b, overrun_b, ones_vld_b;
  logic [10:0]   ones_cnt_b;

  sign_packer #(.DIM(64)) dut_a (
    .clk(clk), .rst(rst), .capture(capture_a), .sign_vec(vec_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_last(m_last_a),
    .m_ready(m_ready_a), .busy(busy_a), .overrun(overrun_a),
    .ones_cnt(ones_cnt_a), .ones_vld(ones_vld_a)
  );

  sign_packer #(.DIM(1024)) dut_b (
    .clk(clk), .rst(rst), .capture(capture_b), .sign_vec(vec_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_last(m_last_b),
    .m_ready(m_ready_b), .busy(busy_b), .overrun(overrun_b),
    .ones_cnt(ones_cnt_b), .ones_vld(ones_vld_b)
  );

  localparam logic [63:0] V1 = 64'hF0F0_0000_0000_0001;
  localparam logic [63:0] V2 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] V3 = 64'hA5A5_0F0F_3C3C_7E7E;

  // Expected popcount of a completed 64-bit vector for this build.
  function automatic logic [6:0] exp_cnt(input logic [63:0] v);
`ifdef SIGN_PACK_POPCNT_EN
    return 7'($countones(v));
`else
    return 7'(v & 64'h0);
`endif
  endfunction

  function automatic logic exp_vld();
`ifdef SIGN_PACK_POPCNT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({m_valid_a, m_last_a, busy_a, overrun_a, ones_vld_a} !== 5'b0) begin
      $display("[TB] FAIL reset_flags actual=%b required=00000",
               {m_valid_a, m_last_a, busy_a, overrun_a, ones_vld_a});
      errors++;
    end
    checks++;
    if (m_data_a !== 32'h0 || ones_cnt_a !== 7'h0) begin
      $display("[TB] FAIL reset_data actual=%h/%0d required=0/0", m_data_a, ones_cnt_a);
      errors++;
    end
    checks++;
    if (m_valid_b !== 1'b0 || busy_b !== 1'b0) begin
      $display("[TB] FAIL reset_b actual=%b%b required=00", m_valid_b, busy_b);
      errors++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    capture_a = 1'b1; vec_a = V1; m_ready_a = 1'b1;
    tick();
    capture_a = 1'b0; vec_a = '0;
    checks++;
    if (m_valid_a !== 1'b1 || busy_a !== 1'b1 || m_data_a !== 32'h0000_0001 || m_last_a !== 1'b0) begin
      $display("[TB] FAIL basic_word0 actual=v%b b%b %h l%b required=v1 b1 00000001 l0",
               m_valid_a, busy_a, m_data_a, m_last_a);
      errors++;
    end
    tick();
    checks++;
    if (m_valid_a !== 1'b1 || m_data_a !== 32'hF0F0_0000 || m_last_a !== 1'b1) begin
      $display("[TB] FAIL basic_word1 actual=v%b %h l%b required=v1 f0f00000 l1",
               m_valid_a, m_data_a, m_last_a);
      errors++;
    end
    tick();
    checks++;
    if (m_valid_a !== 1'b0 || busy_a !== 1'b0 || overrun_a !== 1'b0) begin
      $display("[TB] FAIL basic_idle actual=v%b b%b o%b required=v0 b0 o0",
               m_valid_a, busy_a, overrun_a);
      errors++;
    end
    checks++;
    if (ones_vld_a !== exp_vld() || ones_cnt_a !== exp_cnt(V1)) begin
      $display("[TB] FAIL basic_popcnt actual=vld%b cnt%0d required=vld%b cnt%0d",
               ones_vld_a, ones_cnt_a, exp_vld(), exp_cnt(V1));
      errors++;
    end
    tick();
    checks++;
    if (ones_vld_a !== 1'b0 || ones_cnt_a !== exp_cnt(V1)) begin
      $display("[TB] FAIL basic_popcnt_hold actual=vld%b cnt%0d required=vld0 cnt%0d",
               ones_vld_a, ones_cnt_a, exp_cnt(V1));
      errors++;
    end
  endtask

  task automatic test_backpressure();
    capture_a = 1'b1; vec_a = V2; m_ready_a = 1'b0;
    tick();
    capture_a = 1'b0; vec_a = '1;
    tick();
    checks++;
    if (m_valid_a !== 1'b1 || m_data_a !== 32'h9ABC_DEF0 || m_last_a !== 1'b0) begin
      $display("[TB] FAIL bp_hold0 actual=v%b %h l%b required=v1 9abcdef0 l0",
               m_valid_a, m_data_a, m_last_a);
      errors++;
    end
    m_ready_a = 1'b1;
    tick();
    m_ready_a = 1'b0;
    checks++;
    if (m_valid_a !== 1'b1 || m_data_a !== 32'h1234_5678 || m_last_a !== 1'b1) begin
      $display("[TB] FAIL bp_word1 actual=v%b %h l%b required=v1 12345678 l1",
               m_valid_a, m_data_a, m_last_a);
      errors++;
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (m_valid_a !== 1'b1 || m_data_a !== 32'h1234_5678 || m_last_a !== 1'b1) begin
        $display("[TB] FAIL bp_hold1 cycle=%0d actual=v%b %h l%b required=v1 12345678 l1",
                 i, m_valid_a, m_data_a, m_last_a);
        errors++;
      end
    end
    m_ready_a = 1'b1;
    tick();
    checks++;
    if (m_valid_a !== 1'b0 || ones_cnt_a !== exp_cnt(V2)) begin
      $display("[TB] FAIL bp_done actual=v%b cnt%0d required=v0 cnt%0d",
               m_valid_a, ones_cnt_a, exp_cnt(V2));
      errors++;
    end
  endtask

  task automatic test_popcount();
    // V1 then an all-zero vector; ones_cnt must follow each completed vector.
    capture_a = 1'b1; vec_a = V1; m_ready_a = 1'b1;
    tick();
    capture_a = 1'b0;
    tick();
    tick();
    checks++;
    if (ones_cnt_a !== exp_cnt(V1) || ones_vld_a !== exp_vld()) begin
      $display("[TB] FAIL pop_v1 actual=cnt%0d vld%b required=cnt%0d vld%b",
               ones_cnt_a, ones_vld_a, exp_cnt(V1), exp_vld());
      errors++;
    end
    capture_a = 1'b1; vec_a = 64'h0;
    tick();
    capture_a = 1'b0;
    tick();
    tick();
    checks++;
    if (ones_cnt_a !== 7'd0 || ones_vld_a !== exp_vld()) begin
      $display("[TB] FAIL pop_zero actual=cnt%0d vld%b required=cnt0 vld%b",
               ones_cnt_a, ones_vld_a, exp_vld());
      errors++;
    end
  endtask

  task automatic test_overrun();
    capture_a = 1'b1; vec_a = V3; m_ready_a = 1'b1;
    tick();
    vec_a = '1;
    checks++;
    if (m_data_a !== 32'h3C3C_7E7E || overrun_a !== 1'b0) begin
      $display("[TB] FAIL ovr_word0 actual=%h o%b required=3c3c7e7e o0", m_data_a, overrun_a);
      errors++;
    end
    tick();
    capture_a = 1'b0;
    checks++;
    if (m_data_a !== 32'hA5A5_0F0F || m_last_a !== 1'b1 || overrun_a !== 1'b1) begin
      $display("[TB] FAIL ovr_word1 actual=%h l%b o%b required=a5a50f0f l1 o1",
               m_data_a, m_last_a, overrun_a);
      errors++;
    end
    tick();
    checks++;
    if (m_valid_a !== 1'b0 || ones_cnt_a !== exp_cnt(V3)) begin
      $display("[TB] FAIL ovr_idle actual=v%b cnt%0d required=v0 cnt%0d",
               m_valid_a, ones_cnt_a, exp_cnt(V3));
      errors++;
    end
    capture_a = 1'b1;
    tick();
    capture_a = 1'b0;
    checks++;
    if (m_valid_a !== 1'b1 || m_data_a !== 32'hFFFF_FFFF || overrun_a !== 1'b1) begin
      $display("[TB] FAIL ovr_recapture actual=v%b %h o%b required=v1 ffffffff o1",
               m_valid_a, m_data_a, overrun_a);
      errors++;
    end
    tick();
    tick();
    checks++;
    if (m_valid_a !== 1'b0 || ones_cnt_a !== exp_cnt(64'hFFFF_FFFF_FFFF_FFFF)) begin
      $display("[TB] FAIL ovr_ones actual=v%b cnt%0d required=v0 cnt%0d",
               m_valid_a, ones_cnt_a, exp_cnt(64'hFFFF_FFFF_FFFF_FFFF));
      errors++;
    end
  endtask

  task automatic test_reset_mid_stream();
    capture_a = 1'b1; vec_a = V3; m_ready_a = 1'b1;
    tick();
    capture_a = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (m_valid_a !== 1'b0 || busy_a !== 1'b0 || overrun_a !== 1'b0 || m_data_a !== 32'h0) begin
      $display("[TB] FAIL rst_abort actual=v%b b%b o%b %h required=v0 b0 o0 00000000",
               m_valid_a, busy_a, overrun_a, m_data_a);
      errors++;
    end
    checks++;
    if (ones_cnt_a !== 7'd0 || ones_vld_a !== 1'b0) begin
      $display("[TB] FAIL rst_popcnt actual=cnt%0d vld%b required=cnt0 vld0", ones_cnt_a, ones_vld_a);
      errors++;
    end
    capture_a = 1'b1; vec_a = V2;
    tick();
    capture_a = 1'b0;
    checks++;
    if (m_valid_a !== 1'b1 || m_data_a !== 32'h9ABC_DEF0 || m_last_a !== 1'b0) begin
      $display("[TB] FAIL rst_restart actual=v%b %h l%b required=v1 9abcdef0 l0",
               m_valid_a, m_data_a, m_last_a);
      errors++;
    end
    tick();
    tick();
    checks++;
    if (m_valid_a !== 1'b0 || ones_cnt_a !== exp_cnt(V2)) begin
      $display("[TB] FAIL rst_finish actual=v%b cnt%0d required=v0 cnt%0d",
               m_valid_a, ones_cnt_a, exp_cnt(V2));
      errors++;
    end
  endtask

  task automatic test_random_1024();
    logic [1023:0] saved;
    int words;
    int lasts;
    int cyc;
    for (int n = 0; n < 3; n++) begin
      for (int w = 0; w < 32; w++) vec_b[32*w +: 32] = $urandom();
      saved = vec_b;
      capture_b = 1'b1;
      m_ready_b = 1'($urandom_range(0, 1));
      tick();
      capture_b = 1'b0;
      vec_b = ~saved;
      words = 0; lasts = 0; cyc = 0;
      while (words < 32 && cyc < 400) begin
        @(negedge clk);
        if (m_valid_b && m_ready_b) begin
          checks++;
          if (m_data_b !== saved[32*words +: 32] || m_last_b !== (words == 31)) begin
            $display("[TB] FAIL rand_word vec=%0d word=%0d actual=%h l%b required=%h l%b",
                     n, words, m_data_b, m_last_b, saved[32*words +: 32], (words == 31));
            errors++;
          end
          if (m_last_b) lasts++;
          words++;
        end
        @(posedge clk);
        #1;
        m_ready_b = 1'($urandom_range(0, 1));
        cyc++;
      end
      checks++;
      if (words != 32 || lasts != 1 || m_valid_b !== 1'b0) begin
        $display("[TB] FAIL rand_vector vec=%0d actual=words%0d lasts%0d v%b required=words32 lasts1 v0",
                 n, words, lasts, m_valid_b);
        errors++;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    capture_a = 1'b0; vec_a = '0; m_ready_a = 1'b0;
    capture_b = 1'b0; vec_b = '0; m_ready_b = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_popcount();
    test_overrun();
    test_reset_mid_stream();
    test_random_1024();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
